// File: rtl/segrun_pkg.sv
//==============================================================================
// Module : segrun_pkg
// Brief  : Shared constants for the scroll sequencer: FSM encoding, LFSR taps,
//          default timing values and the LFSR step function.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package segrun_pkg;

  localparam logic [2:0] c_stIdle   = 3'd0;
  localparam logic [2:0] c_stLoad   = 3'd1;
  localparam logic [2:0] c_stRun    = 3'd2;
  localparam logic [2:0] c_stPaused = 3'd3;
  localparam logic [2:0] c_stOver   = 3'd4;

  // Feedback taps for x^8+x^6+x^5+x^4+1 in a left-shifting Fibonacci register
  localparam logic [7:0] c_lfsrTaps = 8'b1011_1000;

  localparam logic [23:0] c_initPeriod   = 24'd5_000_000;
  localparam logic [23:0] c_minPeriod    = 24'd1_000_000;
  localparam logic [23:0] c_step         = 24'd250_000;
  localparam logic [7:0]  c_speedupEvery = 8'd16;
  localparam logic [7:0]  c_lfsrSeed     = 8'hA5;
  localparam int          c_minGap       = 2;

  function automatic logic [7:0] lfsrStep(input logic [7:0] v);
    return {v[6:0], ^(v & c_lfsrTaps)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/scroll_ctrl_if.sv
//==============================================================================
// Module : scroll_ctrl_if
// Brief  : Game-control and shift-register strobe bundle of the scroll sequencer.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface scroll_ctrl_if #(
  parameter int WIDTH = 6,
  parameter int PER_W = 24
);
  logic             Start;
  logic             Pause;
  logic             Collision;
  logic             ShiftOut;
  logic             BitOut;
  logic             LoadOut;
  logic [WIDTH-1:0] LoadValue;
  logic             Running;
  logic             GameOver;
  logic [15:0]      Score;
  logic [PER_W-1:0] Period;

  modport master (
    output Start, Pause, Collision,
    input  ShiftOut, BitOut, LoadOut, LoadValue, Running, GameOver, Score, Period
  );

  modport slave (
    input  Start, Pause, Collision,
    output ShiftOut, BitOut, LoadOut, LoadValue, Running, GameOver, Score, Period
  );
endinterface

`default_nettype wire

// File: rtl/obstacle_lfsr.sv
//==============================================================================
// Module : obstacle_lfsr
// Brief  : 8-bit obstacle LFSR with a forced-zero gap counter after every 1.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module obstacle_lfsr
  import segrun_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = c_lfsrSeed,
  parameter int         MIN_GAP   = c_minGap
) (
  input  wire logic Clk,
  input  wire logic Rst,
  input  wire logic init,
  input  wire logic adv,
  output logic      obstBit
);

  localparam int GAP_W = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);

  logic [7:0]       r_lfsr;
  logic [GAP_W-1:0] r_gap;

  // Bit offered for the current tick, taken from the pre-advance register
  assign obstBit = (r_gap == '0) && r_lfsr[0] && r_lfsr[1];

  always_ff @(posedge Clk) begin
    if (Rst || init) begin
      r_lfsr <= LFSR_SEED;
      r_gap  <= '0;
    end else if (adv) begin
      r_lfsr <= lfsrStep(r_lfsr);
      if (r_gap != '0)
        r_gap <= r_gap - 1'b1;
      else if (obstBit)
        r_gap <= GAP_W'(MIN_GAP);
    end
  end

endmodule

`default_nettype wire

// File: rtl/scroll_ctrl.sv
//==============================================================================
// Module : scroll_ctrl
// Brief  : Game FSM, accelerating shift-period timer and score for the obstacle
//          shift register.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module scroll_ctrl
  import segrun_pkg::*;
#(
  parameter int               WIDTH         = 6,
  parameter int               PER_W         = 24,
  parameter logic [PER_W-1:0] INIT_PERIOD   = PER_W'(c_initPeriod),
  parameter logic [PER_W-1:0] MIN_PERIOD    = PER_W'(c_minPeriod),
  parameter logic [PER_W-1:0] STEP          = PER_W'(c_step),
  parameter logic [7:0]       SPEEDUP_EVERY = c_speedupEvery,
  parameter logic [7:0]       LFSR_SEED     = c_lfsrSeed,
  parameter int               MIN_GAP       = c_minGap
) (
  input wire logic    Clk,
  input wire logic    Rst,
  scroll_ctrl_if.slave bus
);

  logic [2:0]       r_state, w_nextState;
  logic [PER_W-1:0] r_cnt, r_period, w_periodNext;
  logic [PER_W:0]   w_stepped;
  logic [7:0]       r_shiftCnt;
  logic [15:0]      r_score;
  logic             r_shiftOut, r_bitOut, r_loadOut, r_running, r_gameOver;
  logic             w_active, w_tick, w_init, w_speedup, w_obstBit;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_stIdle:   if (bus.Start) w_nextState = c_stLoad;
      c_stLoad:   w_nextState = c_stRun;
      c_stRun:    if (bus.Collision) w_nextState = c_stOver;
                  else if (bus.Pause) w_nextState = c_stPaused;
      c_stPaused: if (bus.Collision) w_nextState = c_stOver;
                  else if (!bus.Pause) w_nextState = c_stRun;
      c_stOver:   if (bus.Start) w_nextState = c_stLoad;
      default:    w_nextState = c_stIdle;
    endcase
  end

  assign w_active  = (r_state == c_stRun) && !bus.Collision && !bus.Pause;
  assign w_tick    = w_active && (r_cnt == '0);
  assign w_init    = (w_nextState == c_stLoad);
  assign w_speedup = w_tick && (r_shiftCnt == SPEEDUP_EVERY - 8'd1);
  assign w_stepped = {1'b0, r_period} - {1'b0, STEP};

  always_comb begin
    w_periodNext = r_period;
    if (w_speedup)
      w_periodNext = (w_stepped[PER_W] || (w_stepped[PER_W-1:0] < MIN_PERIOD))
                     ? MIN_PERIOD : w_stepped[PER_W-1:0];
  end

  obstacle_lfsr #(
    .LFSR_SEED (LFSR_SEED),
    .MIN_GAP   (MIN_GAP)
  ) u_lfsr (
    .Clk     (Clk),
    .Rst     (Rst),
    .init    (w_init),
    .adv     (w_tick),
    .obstBit (w_obstBit)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= c_stIdle;
      r_cnt      <= '0;
      r_period   <= INIT_PERIOD;
      r_shiftCnt <= '0;
      r_score    <= '0;
      r_shiftOut <= 1'b0;
      r_bitOut   <= 1'b0;
      r_loadOut  <= 1'b0;
      r_running  <= 1'b0;
      r_gameOver <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_shiftOut <= w_tick;
      r_bitOut   <= w_tick && w_obstBit;
      r_loadOut  <= w_init;
      r_running  <= (w_nextState == c_stRun);
      r_gameOver <= (w_nextState == c_stOver);
      // The LOAD cycle also counts down once so the first strobe lands on RUN cycle INIT_PERIOD
      if (w_init) begin
        r_cnt      <= INIT_PERIOD - 1'b1;
        r_period   <= INIT_PERIOD;
        r_shiftCnt <= '0;
        r_score    <= '0;
      end else if ((r_state == c_stLoad) || (w_active && !w_tick)) begin
        r_cnt <= r_cnt - 1'b1;
      end else if (w_tick) begin
        r_cnt      <= w_periodNext - 1'b1;
        r_period   <= w_periodNext;
        r_shiftCnt <= w_speedup ? 8'd0 : r_shiftCnt + 8'd1;
        if (r_score != 16'hFFFF)
          r_score <= r_score + 16'd1;
      end
    end
  end

  assign bus.ShiftOut  = r_shiftOut;
  assign bus.BitOut    = r_bitOut;
  assign bus.LoadOut   = r_loadOut;
  assign bus.LoadValue = '0;
  assign bus.Running   = r_running;
  assign bus.GameOver  = r_gameOver;
  assign bus.Score     = r_score;
  assign bus.Period    = r_period;

endmodule

`default_nettype wire

// File: tb/tb_scroll_ctrl.sv
//==============================================================================
// Module : tb_scroll_ctrl
// Brief  : Self-checking bench for scroll_ctrl with a behavioural game model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_scroll_ctrl;

  localparam int INIT = 4;
  localparam int MINP = 2;
  localparam int STEP = 1;
  localparam int SE   = 3;
  localparam int GAP  = 2;
  localparam logic [7:0] SEED = 8'hA5;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  scroll_ctrl_if #(.WIDTH(6), .PER_W(24)) bus ();

  scroll_ctrl #(
    .WIDTH(6), .PER_W(24), .INIT_PERIOD(24'd4), .MIN_PERIOD(24'd2), .STEP(24'd1),
    .SPEEDUP_EVERY(8'd3), .LFSR_SEED(8'hA5), .MIN_GAP(2)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int nChecks = 0;
  int nErrors = 0;

  typedef enum {M_IDLE, M_LOAD, M_RUN, M_PAUSED, M_OVER} mstate_t;
  mstate_t    mState = M_IDLE;
  int         mRemain = 0;
  int         mTicks = 0;
  int         mScore = 0;
  int         mGap = 0;
  logic [7:0] mLfsr = 8'hA5;
  logic       eShift, eBit, eLoad;
  int         zerosSinceOne = 99;

  typedef struct {
    logic st; logic pa; logic co;
    logic shift; logic load; logic run; int score; int period;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeoutFail(input string nm);
    nChecks++;
    nErrors++;
    $display("FAIL %s: expected event never arrived at %0t", nm, $time);
  endtask

  function automatic int perOf(input int k);
    int p;
    p = INIT - STEP * (k / SE);
    return (p < MINP) ? MINP : p;
  endfunction

  function automatic logic [7:0] lfsrNext(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic newGame();
    mScore = 0; mTicks = 0; mLfsr = SEED; mGap = 0;
  endtask

  // Advance the game model by one clock edge with the inputs sampled there
  task automatic modelStep(input logic st, input logic pa, input logic co, input logic rs);
    eShift = 1'b0; eBit = 1'b0; eLoad = 1'b0;
    if (rs) begin
      mState = M_IDLE;
      newGame();
    end else begin
      case (mState)
        M_IDLE, M_OVER: if (st) begin
          mState = M_LOAD; eLoad = 1'b1; newGame(); mRemain = INIT - 1;
        end
        M_LOAD: mState = M_RUN;
        M_RUN: begin
          if (co) mState = M_OVER;
          else if (pa) mState = M_PAUSED;
          else begin
            mRemain--;
            if (mRemain == 0) begin
              eShift = 1'b1;
              if (mGap > 0) mGap--;
              else begin
                eBit = mLfsr[0] & mLfsr[1];
                if (eBit) mGap = GAP;
              end
              mLfsr = lfsrNext(mLfsr);
              mTicks++;
              if (mScore < 65535) mScore++;
              mRemain = perOf(mTicks);
            end
          end
        end
        M_PAUSED: if (co) mState = M_OVER; else if (!pa) mState = M_RUN;
        default: mState = M_IDLE;
      endcase
    end
  endtask

  task automatic cycle(input logic st, input logic pa, input logic co, input logic rs);
    bus.Start = st; bus.Pause = pa; bus.Collision = co; Rst = rs;
    @(posedge Clk);
    modelStep(st, pa, co, rs);
    #1;
    chk("ShiftOut", bus.ShiftOut, eShift);
    chk("BitOut", bus.BitOut, eBit);
    chk("LoadOut", bus.LoadOut, eLoad);
    chk("LoadValue", bus.LoadValue, 0);
    chk("Running", bus.Running, mState == M_RUN);
    chk("GameOver", bus.GameOver, mState == M_OVER);
    chk("Score", bus.Score, mScore);
    chk("Period", bus.Period, perOf(mTicks));
    if (!bus.ShiftOut) chk("BitIdle", bus.BitOut, 0);
    if (rs || bus.LoadOut) zerosSinceOne = 99;
    else if (bus.ShiftOut) begin
      if (bus.BitOut) begin
        chk("ZeroGap", zerosSinceOne >= GAP, 1);
        zerosSinceOne = 0;
      end else zerosSinceOne++;
    end
  endtask

  initial begin
    int  saved;
    int  n;
    logic done;
    logic pa;

    // Start from reset: load, run, strobes on RUN cycles 4, 8, 12, 15; speed-up after 3rd
    tbl[0]  = '{1,0,0, 0,1,0, 0,4};
    tbl[1]  = '{0,0,0, 0,0,1, 0,4};
    tbl[2]  = '{0,0,0, 0,0,1, 0,4};
    tbl[3]  = '{0,0,0, 0,0,1, 0,4};
    tbl[4]  = '{0,0,0, 1,0,1, 1,4};
    tbl[5]  = '{0,0,0, 0,0,1, 1,4};
    tbl[6]  = '{0,0,0, 0,0,1, 1,4};
    tbl[7]  = '{0,0,0, 0,0,1, 1,4};
    tbl[8]  = '{0,0,0, 1,0,1, 2,4};
    tbl[9]  = '{0,0,0, 0,0,1, 2,4};
    tbl[10] = '{0,0,0, 0,0,1, 2,4};
    tbl[11] = '{0,0,0, 0,0,1, 2,4};
    tbl[12] = '{0,0,0, 1,0,1, 3,3};
    tbl[13] = '{0,0,0, 0,0,1, 3,3};
    tbl[14] = '{0,0,0, 0,0,1, 3,3};
    tbl[15] = '{0,0,0, 1,0,1, 4,3};

    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    chk("rstPeriod", bus.Period, INIT);
    chk("rstRunning", bus.Running, 0);

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].st, tbl[i].pa, tbl[i].co, 0);
      chk($sformatf("tbl%0d.shift", i), bus.ShiftOut, tbl[i].shift);
      chk($sformatf("tbl%0d.load", i), bus.LoadOut, tbl[i].load);
      chk($sformatf("tbl%0d.run", i), bus.Running, tbl[i].run);
      chk($sformatf("tbl%0d.score", i), bus.Score, tbl[i].score);
      chk($sformatf("tbl%0d.period", i), bus.Period, tbl[i].period);
    end

    // Pause for 10 cycles mid-period: strobe gap stretches by the pause plus the resume cycle
    cycle(0, 0, 0, 0);
    saved = 4;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 0, 0);
      chk("pauseNoShift", bus.ShiftOut, 0);
      chk("pauseScore", bus.Score, saved);
    end
    n = 11;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle(0, 0, 0, 0);
      n++;
      if (bus.ShiftOut) done = 1'b1;
    end
    if (!done) timeoutFail("pauseResume");
    else chk("pauseGap", n, perOf(4) + 11);

    // Collision on the edge that would have produced a strobe
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (mState == M_RUN && mRemain == 1) begin
        saved = mScore;
        cycle(0, 0, 1, 0);
        chk("collNoShift", bus.ShiftOut, 0);
        chk("collGameOver", bus.GameOver, 1);
        chk("collScore", bus.Score, saved);
        done = 1'b1;
      end else cycle(0, 0, 0, 0);
    end
    if (!done) timeoutFail("collisionTick");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("overHold", bus.GameOver, 1);
    cycle(1, 0, 0, 0);
    chk("restartLoad", bus.LoadOut, 1);
    chk("restartScore", bus.Score, 0);
    chk("restartPeriod", bus.Period, INIT);

    // Reset mid-run at Score 7 on a would-be tick edge
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (mState == M_RUN && mScore == 7 && mRemain == 1) begin
        cycle(0, 0, 0, 1);
        chk("rstMidShift", bus.ShiftOut, 0);
        chk("rstMidScore", bus.Score, 0);
        chk("rstMidPeriod", bus.Period, INIT);
        chk("rstMidRunning", bus.Running, 0);
        chk("rstMidOver", bus.GameOver, 0);
        done = 1'b1;
      end else cycle(0, 0, 0, 0);
    end
    if (!done) timeoutFail("resetAtScore7");

    // Long uninterrupted run reaching the period floor
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 120; i++) cycle(0, 0, 0, 0);
    chk("floorPeriod", bus.Period, MINP);

    // Randomised play checked cycle by cycle against the model
    pa = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) pa = ~pa;
      cycle($urandom_range(0, 15) == 0, pa, $urandom_range(0, 149) == 0,
            $urandom_range(0, 799) == 0);
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

`default_nettype wire
